// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Round-robin arbiter and sequencer that shares one single-port memory
// between an instruction-fetch port (reads only) and a data port
// (loads and stores). Only one transaction is in flight at a time.
// Every output is registered.
module mem_port_arbiter #(
  parameter int RD_LAT   = 1,
  parameter int ADDR_MAX = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_ack,
  output logic [31:0] f_data,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        err,
  output logic        busy,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0]  CNT_INIT   = 4'(RD_LAT - 1);
  localparam logic [15:0] ADDR_LIMIT = 16'(ADDR_MAX);

  state_t      state_reg;
  logic        last_d_reg;   // 1 when the data port won the most recent grant
  logic        grant_d_reg;  // 1 when the current transaction belongs to the data port
  logic        we_reg;
  logic        oor_reg;      // latched address lies above ADDR_MAX
  logic [3:0]  cnt_reg;

  logic        pick_f;
  logic [15:0] sel_addr;
  logic        sel_we;
  logic        sel_oor;

  // Arbitration: a lone requester wins, a conflict goes to the port not granted last
  always_comb begin
    pick_f   = f_req && (!d_req || last_d_reg);
    sel_addr = pick_f ? f_addr : d_addr;
    sel_we   = !pick_f && d_we;
    sel_oor  = sel_addr > ADDR_LIMIT;
  end

  // Sequencer: grant, issue one command, wait out the read latency, acknowledge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      last_d_reg  <= 1'b1;
      grant_d_reg <= 1'b0;
      we_reg      <= 1'b0;
      oor_reg     <= 1'b0;
      cnt_reg     <= 4'd0;
      f_ack       <= 1'b0;
      d_ack       <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
      f_data      <= 32'd0;
      d_rdata     <= 16'd0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= 16'd0;
      mem_wdata   <= 16'd0;
    end else begin
      // Pulses last a single cycle unless re-armed below
      f_ack     <= 1'b0;
      d_ack     <= 1'b0;
      err       <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (f_req || d_req) begin
            grant_d_reg <= !pick_f;
            last_d_reg  <= !pick_f;
            we_reg      <= sel_we;
            oor_reg     <= sel_oor;
            busy        <= 1'b1;
            state_reg   <= ISSUE;
            // Strobes are armed here so they are visible during ISSUE;
            // an out-of-range access never touches the memory bus.
            if (!sel_oor) begin
              mem_addr  <= sel_addr;
              mem_read  <= !sel_we;
              mem_write <= sel_we;
              if (sel_we) begin
                mem_wdata <= d_wdata;
              end
            end
          end
        end
        ISSUE: begin
          if (oor_reg) begin
            err       <= 1'b1;
            f_ack     <= !grant_d_reg;
            d_ack     <= grant_d_reg;
            // A rejected read returns zero; a rejected store leaves d_rdata alone
            if (!we_reg) begin
              if (grant_d_reg) begin
                d_rdata <= 16'd0;
              end else begin
                f_data  <= 32'd0;
              end
            end
            state_reg <= RESP;
          end else if (we_reg) begin
            d_ack     <= 1'b1;
            state_reg <= RESP;
          end else begin
            cnt_reg   <= CNT_INIT;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            f_ack <= !grant_d_reg;
            d_ack <= grant_d_reg;
            err   <= !mem_valid;
            if (grant_d_reg) begin
              d_rdata <= mem_rdata[15:0];
            end else begin
              f_data  <= mem_rdata;
            end
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed, table-driven bench for mem_port_arbiter. One instance runs
// with the default read latency against a small memory model; a second
// instance runs with RD_LAT=3 to exercise the latency counter and the
// mem_valid error path.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic        f_req, d_req, d_we;
  logic [15:0] f_addr, d_addr, d_wdata;
  logic        f_ack, d_ack, err, busy, mem_read, mem_write;
  logic [31:0] f_data;
  logic [15:0] d_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_valid;

  logic        f_req3, d_req3, d_we3;
  logic [15:0] f_addr3, d_addr3, d_wdata3;
  logic        f_ack3, d_ack3, err3, busy3, mem_read3, mem_write3;
  logic [31:0] f_data3;
  logic [15:0] d_rdata3, mem_addr3, mem_wdata3;
  logic [31:0] mem_rdata3;
  logic        mem_valid3;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:63];

  mem_port_arbiter #(.RD_LAT(1), .ADDR_MAX(50)) u_dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_data(f_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  mem_port_arbiter #(.RD_LAT(3), .ADDR_MAX(50)) u_lat3 (
    .clk(clk), .rst(rst),
    .f_req(f_req3), .f_addr(f_addr3), .f_ack(f_ack3), .f_data(f_data3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_ack(d_ack3), .d_rdata(d_rdata3), .err(err3), .busy(busy3),
    .mem_read(mem_read3), .mem_write(mem_write3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .mem_valid(mem_valid3)
  );

  always #5 clk = ~clk;

  // Memory model: contents refilled during reset, registered read data held until the next read
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        mem[i] <= {16'hA5A5, 16'(i)};
      end
      mem[1]    <= 32'h48204001;
      mem_rdata <= 32'd0;
    end else begin
      if (mem_write) mem[mem_addr[5:0]] <= {16'h0000, mem_wdata};
      if (mem_read)  mem_rdata <= mem[mem_addr[5:0]];
    end
  end

  // Memory model for the RD_LAT=3 instance: data word encodes the address
  always @(posedge clk) begin
    if (rst) mem_rdata3 <= 32'd0;
    else if (mem_read3) mem_rdata3 <= 32'hC0DE0000 | {16'h0000, mem_addr3};
  end

  typedef struct {
    bit          is_f;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          exp_cyc;
    logic [31:0] exp_data;
    bit          exp_err;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_txn(input int idx, input vec_t v);
    int          ack_cyc, rd_n, wr_n, strobe_cyc;
    logic [15:0] strobe_addr, strobe_wdata;
    logic        got_err, other_ack;
    logic [31:0] got_data;
    ack_cyc = -1; rd_n = 0; wr_n = 0; strobe_cyc = -1;
    strobe_addr = 16'd0; strobe_wdata = 16'd0;
    got_err = 1'b0; other_ack = 1'b0; got_data = 32'd0;
    @(posedge clk); #1;
    if (v.is_f) begin
      f_req = 1'b1; f_addr = v.addr;
    end else begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end
    for (int c = 0; c < 20 && ack_cyc < 0; c++) begin
      @(negedge clk);
      if (mem_read)  begin rd_n++; strobe_cyc = c; strobe_addr = mem_addr; end
      if (mem_write) begin wr_n++; strobe_cyc = c; strobe_addr = mem_addr; strobe_wdata = mem_wdata; end
      if (v.is_f ? d_ack : f_ack) other_ack = 1'b1;
      if (v.is_f ? f_ack : d_ack) begin
        ack_cyc  = c;
        got_err  = err;
        got_data = v.is_f ? f_data : {16'h0000, d_rdata};
        f_req = 1'b0; d_req = 1'b0;
      end
    end
    check($sformatf("v%0d_ack_cycle", idx), 32'(ack_cyc), 32'(v.exp_cyc));
    check($sformatf("v%0d_data", idx), got_data, v.exp_data);
    check($sformatf("v%0d_err", idx), 32'(got_err), 32'(v.exp_err));
    check($sformatf("v%0d_read_strobes", idx), 32'(rd_n), 32'(v.exp_rd));
    check($sformatf("v%0d_write_strobes", idx), 32'(wr_n), 32'(v.exp_wr));
    check($sformatf("v%0d_other_ack", idx), 32'(other_ack), 32'd0);
    if (rd_n + wr_n > 0) begin
      check($sformatf("v%0d_strobe_cycle", idx), 32'(strobe_cyc), 32'd1);
      check($sformatf("v%0d_strobe_addr", idx), 32'(strobe_addr), 32'(v.addr));
    end
    if (wr_n > 0) check($sformatf("v%0d_strobe_wdata", idx), 32'(strobe_wdata), 32'(v.wdata));
    @(negedge clk);
    check($sformatf("v%0d_post_ack_pulses", idx), {28'd0, f_ack, d_ack, err, busy}, 32'd0);
  endtask

  task automatic lat3_fetch(input logic [15:0] a, input logic valid, input logic exp_err);
    int          ack_cyc, rd_n;
    logic        got_err;
    logic [31:0] got_data;
    ack_cyc = -1; rd_n = 0; got_err = 1'b0; got_data = 32'd0;
    @(posedge clk); #1;
    mem_valid3 = valid; f_req3 = 1'b1; f_addr3 = a;
    for (int c = 0; c < 20 && ack_cyc < 0; c++) begin
      @(negedge clk);
      if (mem_read3) rd_n++;
      if (f_ack3) begin
        ack_cyc = c; got_err = err3; got_data = f_data3; f_req3 = 1'b0;
      end
    end
    check($sformatf("lat3_v%0d_ack_cycle", valid), 32'(ack_cyc), 32'd5);
    check($sformatf("lat3_v%0d_err", valid), 32'(got_err), 32'(exp_err));
    check($sformatf("lat3_v%0d_data", valid), got_data, 32'hC0DE0000 | {16'h0000, a});
    check($sformatf("lat3_v%0d_read_strobes", valid), 32'(rd_n), 32'd1);
  endtask

  initial begin
    int f_hits, aborted_acks;

    //            is_f we  addr      wdata     cyc data           err rd wr
    vecs[0] = '{1'b1, 1'b0, 16'd1,    16'h0000, 3, 32'h48204001, 1'b0, 1, 0};
    vecs[1] = '{1'b0, 1'b1, 16'd5,    16'hBEEF, 2, 32'h00000000, 1'b0, 0, 1};
    vecs[2] = '{1'b0, 1'b0, 16'd5,    16'h0000, 3, 32'h0000BEEF, 1'b0, 1, 0};
    vecs[3] = '{1'b0, 1'b0, 16'd51,   16'h0000, 2, 32'h00000000, 1'b1, 0, 0};
    vecs[4] = '{1'b0, 1'b1, 16'd7,    16'h1357, 2, 32'h00000000, 1'b0, 0, 1};
    vecs[5] = '{1'b0, 1'b0, 16'd7,    16'h0000, 3, 32'h00001357, 1'b0, 1, 0};
    vecs[6] = '{1'b0, 1'b1, 16'd60,   16'hAAAA, 2, 32'h00001357, 1'b1, 0, 0};
    vecs[7] = '{1'b1, 1'b0, 16'd50,   16'h0000, 3, 32'hA5A50032, 1'b0, 1, 0};
    vecs[8] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 2, 32'h00000000, 1'b1, 0, 0};
    vecs[9] = '{1'b1, 1'b0, 16'd0,    16'h0000, 3, 32'hA5A50000, 1'b0, 1, 0};

    rst = 1'b1;
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; f_addr = 16'd0; d_addr = 16'd0; d_wdata = 16'd0;
    f_req3 = 1'b0; d_req3 = 1'b0; d_we3 = 1'b0; f_addr3 = 16'd0; d_addr3 = 16'd0; d_wdata3 = 16'd0;
    mem_valid = 1'b1; mem_valid3 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {26'd0, f_ack, d_ack, err, busy, mem_read, mem_write}, 32'd0);
    check("reset_f_data", f_data, 32'd0);
    check("reset_d_rdata_mem_addr", {d_rdata, mem_addr}, 32'd0);
    check("reset_mem_wdata", 32'(mem_wdata), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_txn(i, vecs[i]);
    end

    // Reset asserted while a fetch sits in WAIT
    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 16'd2;
    @(negedge clk);   // cycle 0
    @(negedge clk);   // cycle 1, ISSUE
    @(negedge clk);   // cycle 2, WAIT
    check("midwait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    f_req = 1'b0;
    @(negedge clk);
    check("midwait_rst_ctrl", {26'd0, f_ack, d_ack, err, busy, mem_read, mem_write}, 32'd0);
    check("midwait_rst_f_data", f_data, 32'd0);
    check("midwait_rst_d_rdata_mem_addr", {d_rdata, mem_addr}, 32'd0);
    check("midwait_rst_mem_wdata", 32'(mem_wdata), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    aborted_acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (f_ack || d_ack) aborted_acks++;
    end
    check("midwait_no_ack", 32'(aborted_acks), 32'd0);

    // Contention straight out of reset: fetch wins first, then alternation
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    f_req = 1'b1; f_addr = 16'd2; d_req = 1'b1; d_we = 1'b0; d_addr = 16'd3;
    f_hits = 0;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      check($sformatf("cont_f_ack_c%0d", c), 32'(f_ack), 32'((c == 3) || (c == 11)));
      check($sformatf("cont_d_ack_c%0d", c), 32'(d_ack), 32'((c == 7) || (c == 15)));
      if (c == 3)  check("cont_f_data", f_data, 32'hA5A50002);
      if (c == 7)  check("cont_d_rdata", 32'(d_rdata), 32'h00000003);
      if (f_ack) f_hits++;
    end
    f_req = 1'b0; d_req = 1'b0;
    check("cont_f_ack_count", 32'(f_hits), 32'd2);
    repeat (6) @(negedge clk);

    // Longer latency with and without a valid memory response
    lat3_fetch(16'd4, 1'b0, 1'b1);
    lat3_fetch(16'd6, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single-port demo memory (16-bit address, 16-bit write data, 32-bit registered read data with `valid`).
- Shares the memory between the instruction-fetch port (read-only) and the data port (load/store).
- Uses round-robin arbitration, one outstanding transaction at a time.
- Issues exactly one memory command per grant and captures read data after a fixed latency.
- Returns a one-cycle acknowledge to the winner.
- Sits between the NanoQuarter fetch/memory stages and the memory model.

## Interface
- `RD_LAT`, 1 — memory read latency in cycles, from the `mem_read` cycle to data capture; legal range 1–15.
- `ADDR_MAX`, 50 — highest legal word address; higher addresses are rejected without a memory access.
- `clk` in 1 — clock; all logic is rising-edge.
- `rst` in 1 — reset, asynchronous, active-high.
- `f_req` in 1 — fetch request, held until `f_ack`.
- `f_addr` in 16 — fetch address, stable while `f_req` is high.
- `f_ack` out 1 — one-cycle fetch completion pulse.
- `f_data` out 32 — fetched word; valid in the `f_ack` cycle and held until the next fetch completion.
- `d_req` in 1 — data request, held until `d_ack`.
- `d_we` in 1 — 1 = store, 0 = load; stable while `d_req` is high.
- `d_addr` in 16 — data address.
- `d_wdata` in 16 — store data.
- `d_ack` out 1 — one-cycle data completion pulse.
- `d_rdata` out 16 — load result, `mem_rdata[15:0]`; valid in the `d_ack` cycle and held afterwards.
- `err` out 1 — high only in an ack cycle; flags an out-of-range address or `mem_valid` low at capture.
- `busy` out 1 — high in every state except IDLE.
- `mem_read` out 1 — memory read strobe.
- `mem_write` out 1 — memory write strobe.
- `mem_addr` out 16 — memory address.
- `mem_wdata` out 16 — memory write data.
- `mem_rdata` in 32 — memory read data.
- `mem_valid` in 1 — memory read-valid. It may stay high indefinitely, so it is only sampled at capture.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If either request is high, pick a winner.
  - Register the grant (F or D), the address, and, for D, the `we` and `wdata` values.
  - Go to ISSUE. With no request, stay in IDLE.
- **Arbitration**
  - With a single requester, that requester wins.
  - With both requesting, the port not granted last wins.
  - The `last` pointer updates on each grant and resets to D, so fetch wins the first conflict.
- **ISSUE, out-of-range address** (latched address > `ADDR_MAX`):
  - No strobe is driven.
  - Set the error flag, clear the capture register, go to RESP.
- **ISSUE, write:**
  - Drive `mem_write`=1 with `mem_addr`/`mem_wdata` for exactly this cycle, then go to RESP.
- **ISSUE, read:**
  - Drive `mem_read`=1 with `mem_addr` for exactly this cycle.
  - Load `cnt` = `RD_LAT`-1, then go to WAIT.
- **WAIT**
  - If `cnt`==0: capture `mem_rdata`, set the error flag = `!mem_valid`, go to RESP.
  - Otherwise decrement `cnt`.
- **RESP**
  - Pulse the granted port's ack, drive `err` from the flag, update `f_data` or `d_rdata` (reads only; stores leave `d_rdata` unchanged).
  - Go to IDLE.
- **Strobes:** `mem_read`/`mem_write` are never high together and never high outside ISSUE. `mem_addr`/`mem_wdata` hold their last value otherwise.
- **Requester rule:** a requester whose request is still high in the cycle after its ack is treated as a new request.
- **Reset (including mid-transaction)**
  - State returns to IDLE, `last` returns to D.
  - Every output is 0, including `f_data`, `d_rdata` and `mem_addr`.
  - No ack is emitted for an aborted transaction.
  - Requesters must re-request.

## Timing
- Cycle numbering: cycle 0 is the IDLE cycle in which the request is sampled.
- Read: `mem_read` at cycle 1, capture at cycle 1+`RD_LAT`, ack at cycle 2+`RD_LAT` (cycle 3 at default).
- Write: `mem_write` at cycle 1, ack at cycle 2.
- Out-of-range: ack with `err`=1 at cycle 2, no strobe.
- Back-to-back: the next grant is sampled in the IDLE cycle following RESP. Minimum spacing is 4 cycles per default read and 3 per write.
- Simultaneous `f_req`/`d_req` arrival in IDLE resolves in the same cycle; the loser waits for the winner's RESP+1 IDLE.

## Test plan
- **Reset:** reset asserted mid-WAIT → next cycle all outputs 0, `busy`=0; no ack is ever emitted for the aborted read.
- **Single fetch:** `f_req`=1, `f_addr`=1, memory word 1 = 0x48204001 → `mem_read` high at cycle 1 only; `f_ack`=1 at cycle 3 with `f_data`=0x48204001 and `err`=0.
- **Store then load:** store (`d_we`=1, `d_addr`=5, `d_wdata`=0xBEEF) → `d_ack` at cycle 2. Then load `d_addr`=5 → `d_ack` at cycle 3 with `d_rdata`=0xBEEF.
- **Contention:** `f_req` and `d_req` held high continuously after reset → grant order F, D, F, D; acks at cycles 3, 7, 11, 15 (all reads).
- **Out of range:** `d_addr`=51 → no `mem_read`/`mem_write` pulse; `d_ack`=1 with `err`=1 at cycle 2; `d_rdata`=0.
- **Latency and invalid data:** `RD_LAT`=3 with `mem_valid` held 0 → ack at cycle 5 with `err`=1. Repeat with `mem_valid`=1 → `err`=0.
